// File: rtl/ethpipe_pkg.sv
// Shared constants and types for the Ethernet receive pipeline.
// Holds the phy FIFO tag encodings, the header size and the packer state enum.
package ethpipe_pkg;

    localparam logic [1:0] TAG_PAIR = 2'b11;
    localparam logic [1:0] TAG_ODD  = 2'b10;
    localparam logic [1:0] TAG_END  = 2'b00;

    localparam int HDR_BYTES = 10;

    localparam logic [7:0] GMII_SFD = 8'hD5;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        HDR,
        PRE,
        DATA,
        TERM,
        LEN,
        DISCARD
    } rx_state_e;

endpackage

// File: rtl/rx_byte_pairer.sv
// Packs a byte stream into big-endian 16-bit words.
// Ports: sys_clk, sys_rst_n, clr, byte_vld/byte_in in; pair_vld/pair_word, pend/pend_byte out.
module rx_byte_pairer (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic        pair_vld,
    output logic [15:0] pair_word,
    output logic        pend,
    output logic [7:0]  pend_byte
);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            pend      <= 1'b0;
            pend_byte <= 8'h00;
        end else if (byte_vld) begin
            pend <= ~pend;
            if (!pend) begin
                pend_byte <= byte_in;
            end
        end
    end

    // A word completes on the byte that arrives while one is already held.
    assign pair_vld  = byte_vld & pend;
    assign pair_word = {pend_byte, byte_in};

endmodule

// File: rtl/gmii_rx_packer.sv
// GMII receive packer: timestamp + status header, byte pairs, terminator, length entry.
// Ports: sys_clk, sys_rst_n, gmii_rx_dv/er/rxd, global_cnt, phy_din/phy_wr_en/phy_afull,
// len_din/len_wr_en/len_full, stat_frames/stat_drops (counters only with RX_STATS_EN).
module gmii_rx_packer
    import ethpipe_pkg::*;
#(
    parameter int         MAX_FRAME_BYTES = 2000,
    parameter logic [7:0] PORT_ID         = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    input  logic [63:0] global_cnt,
    output logic [17:0] phy_din,
    output logic        phy_wr_en,
    input  logic        phy_afull,
    output logic [17:0] len_din,
    output logic        len_wr_en,
    input  logic        len_full,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_drops
);

    localparam logic [11:0] CNT_LIMIT = 12'(MAX_FRAME_BYTES + HDR_BYTES);

    rx_state_e   state, state_n;

    logic        dv_q, er_q;
    logic [7:0]  rxd_q;
    logic [2:0]  hdr_idx;
    logic [63:0] ts_q;
    logic [11:0] byte_cnt;
    logic        trunc, drain;

    logic        start_ok, byte_acc, set_trunc, set_drain;
    logic        phy_we_n, len_we_n;
    logic [17:0] phy_d_n, len_d_n;
    logic [15:0] hdr_word;
    logic        blocked;

    logic        pair_vld, pend, pair_clr;
    logic [15:0] pair_word;
    logic [7:0]  pend_byte;

    assign blocked  = phy_afull | len_full;
    assign pair_clr = (state != DATA) && (state != TERM);

    rx_byte_pairer u_pairer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (pair_clr),
        .byte_vld  (byte_acc),
        .byte_in   (rxd_q),
        .pair_vld  (pair_vld),
        .pair_word (pair_word),
        .pend      (pend),
        .pend_byte (pend_byte)
    );

    always_comb begin
        hdr_word = 16'h0000;
        case (hdr_idx)
            3'd0:    hdr_word = ts_q[63:48];
            3'd1:    hdr_word = ts_q[47:32];
            3'd2:    hdr_word = ts_q[31:16];
            3'd3:    hdr_word = ts_q[15:0];
            default: hdr_word = {PORT_ID, 8'h00};
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        start_ok  = 1'b0;
        byte_acc  = 1'b0;
        set_trunc = 1'b0;
        set_drain = 1'b0;
        phy_we_n  = 1'b0;
        phy_d_n   = 18'h0;
        len_we_n  = 1'b0;
        len_d_n   = 18'h0;
        case (state)
            // Leave only on the raw input so a frame caught by reset is skipped.
            WAIT_IDLE: begin
                if (!gmii_rx_dv) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (dv_q) begin
                    if (blocked) begin
                        state_n = DISCARD;
                    end else begin
                        state_n  = HDR;
                        start_ok = 1'b1;
                    end
                end
            end
            HDR: begin
                phy_we_n  = 1'b1;
                phy_d_n   = {TAG_PAIR, hdr_word};
                set_trunc = dv_q & er_q;
                if (hdr_idx == 3'd4) begin
                    state_n = PRE;
                end
            end
            PRE: begin
                if (!dv_q) begin
                    state_n   = TERM;
                    set_trunc = 1'b1;
                end else begin
                    set_trunc = er_q;
                    if (rxd_q == GMII_SFD) begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (!dv_q) begin
                    state_n = TERM;
                end else begin
                    byte_acc  = 1'b1;
                    phy_we_n  = pair_vld;
                    phy_d_n   = {TAG_PAIR, pair_word};
                    set_trunc = er_q;
                    // This byte is kept; everything after it is dropped.
                    if ((byte_cnt + 12'd1 == CNT_LIMIT) || phy_afull) begin
                        state_n   = TERM;
                        set_trunc = 1'b1;
                        set_drain = 1'b1;
                    end
                end
            end
            TERM: begin
                phy_we_n = 1'b1;
                phy_d_n  = pend ? {TAG_ODD, pend_byte, 8'h00}
                                : {TAG_END, 16'h0000};
                state_n  = LEN;
            end
            LEN: begin
                len_we_n = 1'b1;
                len_d_n  = {1'b1, trunc, 4'h0, byte_cnt};
                if (drain) begin
                    state_n = DISCARD;
                end else if (dv_q) begin
                    // Next frame's preamble already started; accept it now.
                    if (blocked) begin
                        state_n = DISCARD;
                    end else begin
                        state_n  = HDR;
                        start_ok = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            DISCARD: begin
                if (!dv_q) begin
                    state_n = IDLE;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            rxd_q     <= 8'h00;
            hdr_idx   <= 3'd0;
            ts_q      <= 64'h0;
            byte_cnt  <= 12'h0;
            trunc     <= 1'b0;
            drain     <= 1'b0;
            phy_wr_en <= 1'b0;
            phy_din   <= 18'h0;
            len_wr_en <= 1'b0;
            len_din   <= 18'h0;
        end else begin
            dv_q      <= gmii_rx_dv;
            er_q      <= gmii_rx_er;
            rxd_q     <= gmii_rxd;
            phy_wr_en <= phy_we_n;
            phy_din   <= phy_d_n;
            len_wr_en <= len_we_n;
            len_din   <= len_d_n;
            if (start_ok) begin
                ts_q     <= global_cnt;
                byte_cnt <= 12'(HDR_BYTES);
                trunc    <= 1'b0;
                drain    <= 1'b0;
                hdr_idx  <= 3'd0;
            end else begin
                if (state == HDR) begin
                    hdr_idx <= hdr_idx + 3'd1;
                end
                if (byte_acc) begin
                    byte_cnt <= byte_cnt + 12'd1;
                end
                if (set_trunc) begin
                    trunc <= 1'b1;
                end
                if (set_drain) begin
                    drain <= 1'b1;
                end
            end
        end
    end

`ifdef RX_STATS_EN
    logic [31:0] frames_q, drops_q;
    logic        drop_start, frame_done;

    assign frame_done = (state == LEN);
    assign drop_start = dv_q & blocked &
                        ((state == IDLE) || ((state == LEN) && !drain));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            frames_q <= 32'h0;
            drops_q  <= 32'h0;
        end else begin
            if (frame_done) begin
                frames_q <= frames_q + 32'd1;
            end
            drops_q <= drops_q + 32'(drop_start) + 32'(frame_done & trunc);
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
`else
    assign stat_frames = 32'h0;
    assign stat_drops  = 32'h0;
`endif

endmodule

// File: tb/tb_gmii_rx_packer.sv
// Randomised self-checking bench for gmii_rx_packer.
// Expected phy/len streams come from a frame-level model of the packing rules.
module tb_gmii_rx_packer;

    localparam int         MAXB = 2000;
    localparam logic [7:0] PID  = 8'h00;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic [63:0] global_cnt = 64'h0;
    logic        phy_afull = 1'b0;
    logic        len_full = 1'b0;
    logic [17:0] phy_din, len_din;
    logic        phy_wr_en, len_wr_en;
    logic [31:0] stat_frames, stat_drops;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    logic [17:0] got_w[$], got_l[$], exp_w[$], exp_l[$];

    always #5 sys_clk = ~sys_clk;

    gmii_rx_packer #(.MAX_FRAME_BYTES(MAXB), .PORT_ID(PID)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .gmii_rxd    (gmii_rxd),
        .global_cnt  (global_cnt),
        .phy_din     (phy_din),
        .phy_wr_en   (phy_wr_en),
        .phy_afull   (phy_afull),
        .len_din     (len_din),
        .len_wr_en   (len_wr_en),
        .len_full    (len_full),
        .stat_frames (stat_frames),
        .stat_drops  (stat_drops)
    );

    always @(negedge sys_clk) begin
        if (phy_wr_en) got_w.push_back(phy_din);
        if (len_wr_en) got_l.push_back(len_din);
    end

    // Frame-level reference: what the FIFOs must receive for one frame.
    task automatic model(input logic [63:0] ts, input logic [7:0] d[$],
                         input bit er, input bit blocked);
        int n;
        bit tr;
        if (blocked) begin
            exp_drops++;
            return;
        end
        exp_w.push_back({2'b11, ts[63:48]});
        exp_w.push_back({2'b11, ts[47:32]});
        exp_w.push_back({2'b11, ts[31:16]});
        exp_w.push_back({2'b11, ts[15:0]});
        exp_w.push_back({2'b11, PID, 8'h00});
        n  = (d.size() < MAXB) ? d.size() : MAXB;
        tr = er || (d.size() >= MAXB);
        for (int i = 0; i + 1 < n; i += 2)
            exp_w.push_back({2'b11, d[i], d[i+1]});
        if (n % 2 == 1) exp_w.push_back({2'b10, d[n-1], 8'h00});
        else            exp_w.push_back(18'h0);
        exp_l.push_back({1'b1, tr, 4'h0, 12'(n + 10)});
        exp_frames++;
        if (tr) exp_drops++;
    endtask

    task automatic send(input logic [63:0] ts, input logic [7:0] d[$],
                        input int er_idx, input int gap, input int rel_idx);
        global_cnt = ts;
        for (int i = 0; i < 8 + d.size(); i++) begin
            if (i == rel_idx) sys_rst_n = 1'b1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : d[i-8]);
            gmii_rx_er = (er_idx >= 0) && (i - 8 == er_idx);
            @(posedge sys_clk); #1;
        end
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (gap) begin @(posedge sys_clk); #1; end
    endtask

    task automatic clear_q();
        got_w.delete(); got_l.delete(); exp_w.delete(); exp_l.delete();
    endtask

    task automatic settle();
        repeat (16) begin @(posedge sys_clk); #1; end
    endtask

    task automatic test_reset();
        repeat (4) begin @(posedge sys_clk); #1; end
        checks++;
        if (phy_wr_en !== 1'b0 || phy_din !== 18'h0) begin
            errors++;
            $display("FAIL reset_phy got we=%b din=%h want 0/0", phy_wr_en, phy_din);
        end
        checks++;
        if (len_wr_en !== 1'b0 || len_din !== 18'h0) begin
            errors++;
            $display("FAIL reset_len got we=%b din=%h want 0/0", len_wr_en, len_din);
        end
        checks++;
        if (stat_frames !== 32'h0 || stat_drops !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", stat_frames, stat_drops);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d[$];
        clear_q();
        for (int i = 0; i < 40; i++) d.push_back(8'($urandom));
        sys_rst_n = 1'b0;
        exp_frames = 0;
        exp_drops  = 0;
        send(64'h1111_2222_3333_4444, d, -1, 3, 20);
        settle();
        checks++;
        if (got_w.size() != 0 || got_l.size() != 0) begin
            errors++;
            $display("FAIL rst_mid writes got %0d/%0d want 0/0", got_w.size(), got_l.size());
        end
        clear_q();
        d.delete();
        for (int i = 0; i < 17; i++) d.push_back(8'($urandom));
        model(64'hA5A5_0000_5A5A_FFFF, d, 0, 0);
        send(64'hA5A5_0000_5A5A_FFFF, d, -1, 3, -1);
        settle();
        checks++;
        if (got_w.size() != exp_w.size() || got_l.size() != exp_l.size()) begin
            errors++;
            $display("FAIL rst_next count got %0d/%0d want %0d/%0d",
                     got_w.size(), got_l.size(), exp_w.size(), exp_l.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL rst_next w%0d got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (got_l.size() > 0 && got_l[0] !== exp_l[0]) begin
            errors++;
            $display("FAIL rst_next len got %h want %h", got_l[0], exp_l[0]);
        end
    endtask

    task automatic test_frame64();
        logic [7:0] d[$];
        clear_q();
        for (int i = 0; i < 64; i++) d.push_back(8'(i));
        model(64'h0123_4567_89AB_CDEF, d, 0, 0);
        send(64'h0123_4567_89AB_CDEF, d, -1, 4, -1);
        settle();
        checks++;
        if (got_w.size() != 38) begin
            errors++;
            $display("FAIL f64 nwords got %0d want 38", got_w.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL f64 w%0d got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (got_l.size() != 1 || got_l[0] !== 18'h2004A) begin
            errors++;
            $display("FAIL f64 len got n=%0d v=%h want 2004a", got_l.size(),
                     got_l.size() ? got_l[0] : 18'h0);
        end
    endtask

    task automatic test_frame61();
        logic [7:0] d[$];
        clear_q();
        for (int i = 0; i < 61; i++) d.push_back(8'(i));
        model(64'hFEDC_BA98_7654_3210, d, 0, 0);
        send(64'hFEDC_BA98_7654_3210, d, -1, 4, -1);
        settle();
        checks++;
        if (got_w.size() != 36 || got_w[got_w.size()-1] !== {2'b10, 16'h3C00}) begin
            errors++;
            $display("FAIL f61 last n=%0d got %h want 2 3c00", got_w.size(),
                     got_w.size() ? got_w[got_w.size()-1] : 18'h0);
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL f61 w%0d got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (got_l.size() != 1 || got_l[0] !== 18'h20047) begin
            errors++;
            $display("FAIL f61 len got n=%0d want 20047", got_l.size());
        end
    endtask

    task automatic test_afull_drop();
        logic [7:0] d[$];
        clear_q();
        for (int i = 0; i < 30; i++) d.push_back(8'($urandom));
        phy_afull = 1'b1;
        model(64'h5, d, 0, 1);
        send(64'h5, d, -1, 4, -1);
        phy_afull = 1'b0;
        settle();
        checks++;
        if (got_w.size() != 0 || got_l.size() != 0) begin
            errors++;
            $display("FAIL afull writes got %0d/%0d want 0/0", got_w.size(), got_l.size());
        end
    endtask

    task automatic test_truncate();
        logic [7:0] d[$];
        int n11;
        clear_q();
        for (int i = 0; i < 3000; i++) d.push_back(8'($urandom));
        model(64'h0BAD_CAFE_0000_0001, d, 0, 0);
        send(64'h0BAD_CAFE_0000_0001, d, -1, 4, -1);
        settle();
        n11 = 0;
        foreach (got_w[i]) if (got_w[i][17:16] == 2'b11) n11++;
        checks++;
        if (n11 != 1005 || got_w.size() != 1006) begin
            errors++;
            $display("FAIL trunc words got %0d/%0d want 1005/1006", n11, got_w.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL trunc w%0d got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (got_l.size() != 1 || got_l[0] !== 18'h307DA) begin
            errors++;
            $display("FAIL trunc len got n=%0d want 307da", got_l.size());
        end
    endtask

    task automatic test_rx_er();
        logic [7:0] d[$];
        clear_q();
        for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
        model(64'h7, d, 1, 0);
        send(64'h7, d, 10, 4, -1);
        settle();
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL rxer nwords got %0d want %0d", got_w.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL rxer w%0d got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (got_l.size() != 1 || got_l[0] !== 18'h3004A) begin
            errors++;
            $display("FAIL rxer len got n=%0d want 3004a", got_l.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[$];
        logic [63:0] ts;
        int er_i;
        clear_q();
        for (int f = 0; f < 8; f++) begin
            d.delete();
            for (int i = 0; i < $urandom_range(1, 150); i++) d.push_back(8'($urandom));
            ts   = {$urandom, $urandom};
            er_i = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d.size() - 1)) : -1;
            model(ts, d, er_i >= 0, 0);
            send(ts, d, er_i, (f % 2 == 0) ? 1 : $urandom_range(2, 5), -1);
        end
        settle();
        checks++;
        if (got_w.size() != exp_w.size() || got_l.size() != exp_l.size()) begin
            errors++;
            $display("FAIL b2b count got %0d/%0d want %0d/%0d",
                     got_w.size(), got_l.size(), exp_w.size(), exp_l.size());
        end
        foreach (exp_w[i]) if (i < got_w.size()) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b w%0d got %h want %h", i, got_w[i], exp_w[i]);
            end
        end
        foreach (exp_l[i]) if (i < got_l.size()) begin
            checks++;
            if (got_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL b2b len%0d got %h want %h", i, got_l[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_stats();
`ifdef RX_STATS_EN
        checks++;
        if (stat_frames !== 32'(exp_frames) || stat_drops !== 32'(exp_drops)) begin
            errors++;
            $display("FAIL stats got %0d/%0d want %0d/%0d",
                     stat_frames, stat_drops, exp_frames, exp_drops);
        end
`else
        checks++;
        if (stat_frames !== 32'h0 || stat_drops !== 32'h0) begin
            errors++;
            $display("FAIL stats_off got %0d/%0d want 0/0", stat_frames, stat_drops);
        end
`endif
    endtask

    initial begin
        test_reset();
        sys_rst_n = 1'b1;
        repeat (3) begin @(posedge sys_clk); #1; end
        test_reset_midframe();
        test_frame64();
        test_frame61();
        test_afull_drop();
        test_truncate();
        test_rx_er();
        test_back_to_back();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
